// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: converts a synchronous FIFO read port (one-cycle read
// latency) into a valid/ready stream through a 2-entry skid buffer.
// Optional statistics counters (beat_cnt_o, stall_cnt_o) are built only when
// the macro FIFO_RD_STREAM_STATS_EN is defined.
module fifo_rd_stream #(
  parameter int unsigned FifoWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  logic [FifoWidth-1:0] fifo_data_i,
  output logic                 fifo_rd_en_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [FifoWidth-1:0] m_data_o
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]          beat_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned CntW  = 2;
  localparam int unsigned StatW = 32;

  logic [CntW-1:0]      buf_cnt_q, buf_cnt_d;
  logic                 infl_q, infl_d;
  logic [FifoWidth-1:0] head_q, head_d;
  logic [FifoWidth-1:0] tail_q, tail_d;

  logic                 pop;
  logic [CntW-1:0]      occ_after_pop;
  logic [CntW-1:0]      wr_idx;

  // Stream side: head of the buffer, forced quiet while reset is held.
  assign m_valid_o = !rst_i && (buf_cnt_q != CntW'(0));
  assign m_data_o  = rst_i ? '0 : head_q;
  assign pop       = m_valid_o & m_ready_i;

  // Occupancy once this cycle's pop retires; a new read only if room remains
  // for the word it will return (buffer + in-flight never exceeds 2).
  assign occ_after_pop = buf_cnt_q + CntW'(infl_q) - CntW'(pop);
  assign fifo_rd_en_o  = !fifo_empty_i && !flush_i && !rst_i &&
                         (occ_after_pop < CntW'(2));

  // Slot the arriving word lands in after the head has shifted out.
  assign wr_idx = buf_cnt_q - CntW'(pop);

  // Next-state: pop shifts the buffer, arrival writes the tail, flush empties.
  always_comb begin
    buf_cnt_d = buf_cnt_q;
    infl_d    = fifo_rd_en_o;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush_i) begin
      buf_cnt_d = '0;
      infl_d    = 1'b0;
    end else begin
      buf_cnt_d = occ_after_pop;
      if (pop) begin
        head_d = tail_q;
      end
      if (infl_q) begin
        if (wr_idx == CntW'(0)) begin
          head_d = fifo_data_i;
        end else begin
          tail_d = fifo_data_i;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_cnt_q <= '0;
      infl_q    <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      buf_cnt_q <= buf_cnt_d;
      infl_q    <= infl_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [StatW-1:0] beat_cnt_q, beat_cnt_d;
  logic [StatW-1:0] stall_cnt_q, stall_cnt_d;

  // Beat counter wraps; stall counter saturates. Flush leaves both alone.
  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && !flush_i) begin
      beat_cnt_d = beat_cnt_q + StatW'(1);
    end
    if (m_valid_o && !m_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + StatW'(1);
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt_o  = beat_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural upstream FIFO, stream monitor
// and word-sequence scoreboard. Define FIFO_RD_STREAM_STATS_EN to also
// exercise the statistics counters.
module tb_fifo_rd_stream;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst, flush, ready;
  logic         fifo_empty, fifo_rd_en, m_valid;
  logic [W-1:0] fifo_data, m_data;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0]  beat_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_stream #(.FifoWidth(W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_rd_en_o(fifo_rd_en), .m_valid_o(m_valid),
    .m_ready_i(ready), .m_data_o(m_data)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .beat_cnt_o(beat_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  // Upstream FIFO model: every word ever pushed is kept, in order.
  logic [W-1:0] fifo_mem [DEPTH];
  int push_cnt = 0;   // written by stimulus only
  int rd_ptr   = 0;   // written by monitor only
  assign fifo_empty = (push_cnt == rd_ptr);

  // Everything the downstream accepted, in order.
  logic [W-1:0] out_mem [DEPTH];
  int out_n = 0;
  int held = 0;       // words read from the FIFO and not yet delivered/discarded
  int underflow_n = 0, stab_err = 0, occ_err = 0, stall_n = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  int n_tests = 0, n_fail = 0;

  // Upstream FIFO behaviour and stream monitoring on the active edge.
  always @(posedge clk) begin
    logic pop_eff;
    pop_eff = m_valid && ready && !rst && !flush;
    if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      if (fifo_empty) underflow_n <= underflow_n + 1;
    end
    if (pop_eff) begin
      out_mem[out_n] <= m_data;
      out_n          <= out_n + 1;
    end
    if (!rst && m_valid && !ready) stall_n <= stall_n + 1;
    if (prev_hold && !rst && (!m_valid || m_data !== prev_data)) stab_err <= stab_err + 1;
    prev_hold <= m_valid && !ready && !rst && !flush;
    prev_data <= m_data;
    if (held > 2) occ_err <= occ_err + 1;
    if (rst || flush) held <= 0;
    else held <= held + int'(fifo_rd_en) - int'(pop_eff);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_mem[push_cnt] = w;
    push_cnt = push_cnt + 1;
  endtask

  // Wait (bounded) until `n` words have been delivered since `obase`.
  task automatic drain(input int obase, input int n, output bit ok);
    int t;
    t = 0;
    while ((out_n - obase) < n && t < 300) begin
      step(1);
      t++;
    end
    ok = ((out_n - obase) >= n);
    step(3);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; ready = 1'b0;
    step(2);
    for (int k = 1; k <= 8; k++) push(W'(k));
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    n_tests++;
    if (m_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", m_data); end
    step(1);
    n_tests++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold rd_en=%b valid=%b exp=0,0", fifo_rd_en, m_valid);
    end
  endtask

  task automatic test_streaming;
    int obase, errs;
    obase = out_n;
    ready = 1'b1;
    rst   = 1'b0;
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL stream_first_rd got=%b exp=1", fifo_rd_en); end
    step(1);
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_n1 got=%b exp=0", m_valid); end
    for (int k = 1; k <= 8; k++) begin
      step(1);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== W'(k)) begin
        n_fail++; $display("FAIL stream_word%0d valid=%b data=%h exp valid=1 data=%h", k, m_valid, m_data, W'(k));
      end
    end
    step(3);
    errs = 0;
    for (int i = 0; i < 8; i++) if (out_mem[obase+i] !== W'(i + 1)) errs++;
    n_tests++;
    if (errs != 0 || out_n - obase != 8) begin
      n_fail++; $display("FAIL stream_seq got=%0d words, %0d wrong exp=8 words, 0 wrong", out_n - obase, errs);
    end
  endtask

  task automatic test_backpressure;
    int obase, pbase, errs;
    logic [W-1:0] hold_w;
    bit ok;
    obase = out_n; pbase = push_cnt;
    for (int i = 0; i < 12; i++) push(W'($urandom));
    ready = 1'b1;
    step(4);
    ready = 1'b0;
    step(1);
    hold_w = m_data;
    step(4);
    #1;
    n_tests++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en got=%b exp=0", fifo_rd_en); end
    n_tests++;
    if (held != 2) begin n_fail++; $display("FAIL bp_occupancy got=%0d exp=2", held); end
    n_tests++;
    if (m_valid !== 1'b1 || m_data !== hold_w) begin
      n_fail++; $display("FAIL bp_hold valid=%b data=%h exp valid=1 data=%h", m_valid, m_data, hold_w);
    end
    ready = 1'b1;
    drain(obase, 12, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout got=%0d words exp=12", out_n - obase); end
    errs = 0;
    for (int i = 0; i < 12; i++) if (out_mem[obase+i] !== fifo_mem[pbase+i]) errs++;
    n_tests++;
    if (errs != 0 || out_n - obase != 12) begin
      n_fail++; $display("FAIL bp_seq got=%0d words, %0d wrong exp=12 words, 0 wrong", out_n - obase, errs);
    end
    n_tests++;
    if (stab_err != 0) begin n_fail++; $display("FAIL bp_stability got=%0d exp=0", stab_err); end
  endtask

  task automatic test_underflow;
    int obase, rbase;
    obase = out_n; rbase = rd_ptr;
    ready = 1'b1;
    push(16'hBEEF);
    step(8);
    n_tests++;
    if (rd_ptr - rbase != 1) begin n_fail++; $display("FAIL uf_reads got=%0d exp=1", rd_ptr - rbase); end
    n_tests++;
    if (out_n - obase != 1 || out_mem[obase] !== 16'hBEEF) begin
      n_fail++; $display("FAIL uf_word got=%0d words first=%h exp=1 word beef", out_n - obase, out_mem[obase]);
    end
    n_tests++;
    if (underflow_n != 0) begin n_fail++; $display("FAIL uf_underflow got=%0d exp=0", underflow_n); end
  endtask

  task automatic test_flush;
    int obase, pbase, pops_at, rd_at, n_exp, errs;
    logic [W-1:0] exp_q[$];
    bit ok;
    // Case A: buffer full while stalled, flush discards both held words.
    obase = out_n; pbase = push_cnt;
    ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(W'(16'h00A0 + k));
    step(6);
    n_tests++;
    if (held != 2) begin n_fail++; $display("FAIL flushA_fill got=%0d exp=2", held); end
    flush = 1'b1; ready = 1'b1;
    step(1);
    flush = 1'b0;
    rd_at = rd_ptr;
    n_exp = push_cnt - rd_at;
    drain(obase, n_exp, ok);
    errs = 0;
    for (int i = 0; i < n_exp; i++) if (out_mem[obase+i] !== fifo_mem[rd_at+i]) errs++;
    n_tests++;
    if (!ok || errs != 0 || out_n - obase != n_exp || rd_at - pbase != 2) begin
      n_fail++; $display("FAIL flushA_seq got=%0d words, %0d wrong, %0d dropped exp=%0d words, 0 wrong, 2 dropped",
                         out_n - obase, errs, rd_at - pbase, n_exp);
    end
    // Case B: flush mid-stream discards buffered and in-flight words.
    obase = out_n; pbase = push_cnt;
    for (int k = 1; k <= 8; k++) push(W'(16'h00B0 + k));
    drain(obase, 0, ok);
    while (out_n - obase < 2) step(1);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    pops_at = out_n; rd_at = rd_ptr;
    n_tests++;
    if (held != 0 || rd_at - pbase - (pops_at - obase) != 2) begin
      n_fail++; $display("FAIL flushB_discard held=%0d dropped=%0d exp held=0 dropped=2",
                         held, rd_at - pbase - (pops_at - obase));
    end
    for (int i = pbase; i < pbase + (pops_at - obase); i++) exp_q.push_back(fifo_mem[i]);
    for (int i = rd_at; i < push_cnt; i++) exp_q.push_back(fifo_mem[i]);
    drain(obase, exp_q.size(), ok);
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) if (out_mem[obase+i] !== exp_q[i]) errs++;
    n_tests++;
    if (!ok || errs != 0 || out_n - obase != exp_q.size()) begin
      n_fail++; $display("FAIL flushB_seq got=%0d words, %0d wrong exp=%0d words, 0 wrong",
                         out_n - obase, errs, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    int obase, rd_at, n_exp, errs;
    bit ok;
    obase = out_n;
    ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(W'(16'h00C0 + k));
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    n_tests++;
    if (m_valid !== 1'b0 || m_data !== '0) begin
      n_fail++; $display("FAIL rstmid_out valid=%b data=%h exp valid=0 data=0000", m_valid, m_data);
    end
    rd_at = rd_ptr;
    ready = 1'b1;
    n_exp = push_cnt - rd_at;
    drain(obase, n_exp, ok);
    errs = 0;
    for (int i = 0; i < n_exp; i++) if (out_mem[obase+i] !== fifo_mem[rd_at+i]) errs++;
    n_tests++;
    if (!ok || errs != 0 || out_n - obase != n_exp || n_exp != 4) begin
      n_fail++; $display("FAIL rstmid_seq got=%0d words, %0d wrong exp=%0d words (4), 0 wrong", out_n - obase, errs, n_exp);
    end
  endtask

  task automatic test_random;
    int obase, pbase, n_exp, errs;
    bit ok;
    obase = out_n; pbase = push_cnt;
    for (int c = 0; c < 400; c++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && push_cnt < DEPTH - 200) push(W'($urandom));
      step(1);
    end
    ready = 1'b1;
    n_exp = push_cnt - pbase;
    drain(obase, n_exp, ok);
    errs = 0;
    for (int i = 0; i < n_exp; i++) if (out_mem[obase+i] !== fifo_mem[pbase+i]) errs++;
    n_tests++;
    if (!ok || errs != 0 || out_n - obase != n_exp) begin
      n_fail++; $display("FAIL rand_seq got=%0d words, %0d wrong exp=%0d words, 0 wrong", out_n - obase, errs, n_exp);
    end
    n_tests++;
    if (underflow_n != 0 || stab_err != 0 || occ_err != 0) begin
      n_fail++; $display("FAIL rand_rules underflow=%0d unstable=%0d overfill=%0d exp=0,0,0", underflow_n, stab_err, occ_err);
    end
  endtask

`ifdef FIFO_RD_STREAM_STATS_EN
  task automatic test_stats;
    int obase;
    bit ok;
    rst = 1'b1; ready = 1'b1;
    step(1);
    rst = 1'b0;
    obase = out_n;
    for (int k = 0; k < 10; k++) push(W'(16'h0D00 + k));
    while (out_n - obase < 3) step(1);
    ready = 1'b0;
    step(3);
    ready = 1'b1;
    drain(obase, 10, ok);
    n_tests++;
    if (beat_cnt !== 32'd10) begin n_fail++; $display("FAIL stats_beat got=%0d exp=10", beat_cnt); end
    n_tests++;
    if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stats_stall got=%0d exp=3", stall_cnt); end
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    n_tests++;
    if (beat_cnt !== 32'd10 || stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats_flush beat=%0d stall=%0d exp=10,3", beat_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_flush();
    test_reset_mid();
    test_random();
`ifdef FIFO_RD_STREAM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
